led_pattern_driver: RTL and testbench

Parametrised LED output driver for the reaction-timer front panel. It drives NUM_LEDS LEDs in one of four modes: off, blink-all, solid pattern, or rotating chase. All transitions run on a programmable half-period timebase. It replaces the fixed 4-LED, 1 Hz blinker and its hard-coded test-LED path; control logic selects `mode` and `pattern` instead of asserting dedicated wait/test strobes.

---
 rtl/led_pattern_driver.sv | 106 ++++++++++
 tb/tb_led_pattern_driver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: NUM_LEDS-wide LED driver with off / blink / solid / chase
// modes, all stepping on a shared HALF_PERIOD timebase. Outputs are registered;
// there is no combinational path from any input to leds or tick.
module led_pattern_driver #(
    parameter int NUM_LEDS    = 4,
    parameter int HALF_PERIOD = 50000000,
    parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                freeze,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick
);

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_BLINK = 2'd1,
        M_SOLID = 2'd2,
        M_CHASE = 2'd3
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                phase, phase_d;
    logic [NUM_LEDS-1:0] rot, rot_d, rot_l;
    mode_e               mode_q, mode_d, mode_in;
    logic [NUM_LEDS-1:0] leds_d;
    logic                tick_d;
    logic                expire;

    // Rotate-left by one, MSB wrapping to LSB; degenerates to identity for one LED.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_rot
        assign rot_l[i] = rot[(i + NUM_LEDS - 1) % NUM_LEDS];
    end

    assign mode_in = mode_e'(mode);
    assign expire  = (cnt == '0);

    // Next-state: freeze holds everything (tick drops), a mode change re-enters,
    // otherwise the timebase runs and the active mode reacts to expiry.
    always_comb begin
        cnt_d   = cnt;
        phase_d = phase;
        rot_d   = rot;
        mode_d  = mode_q;
        leds_d  = leds;
        tick_d  = 1'b0;
        if (!freeze) begin
            if (mode_in != mode_q) begin
                mode_d  = mode_in;
                cnt_d   = CNT_MAX;
                phase_d = 1'b1;
                rot_d   = pattern;
                case (mode_in)
                    M_OFF:   leds_d = '0;
                    M_BLINK: leds_d = '1;
                    default: leds_d = pattern;
                endcase
            end else begin
                if (expire) begin
                    cnt_d  = CNT_MAX;
                    tick_d = 1'b1;
                end else begin
                    cnt_d  = cnt - CNT_W'(1);
                end
                case (mode_q)
                    M_OFF:   leds_d = '0;
                    M_BLINK: if (expire) begin
                        phase_d = ~phase;
                        leds_d  = {NUM_LEDS{~phase}};
                    end
                    M_SOLID: leds_d = pattern;
                    M_CHASE: if (expire) begin
                        rot_d  = rot_l;
                        leds_d = rot_l;
                    end
                    default: leds_d = leds;
                endcase
            end
        end
    end

    // State register; reset wins over freeze and mode changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= CNT_MAX;
            phase  <= 1'b1;
            rot    <= '0;
            mode_q <= M_OFF;
            leds   <= '0;
            tick   <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            phase  <= phase_d;
            rot    <= rot_d;
            mode_q <= mode_d;
            leds   <= leds_d;
            tick   <= tick_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: directed scenarios plus random traffic, all
// compared cycle by cycle against an elapsed-time / expiry-count model.
module tb_led_pattern_driver;

    localparam int N  = 4;
    localparam int HP = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         freeze;
    logic [1:0]   mode;
    logic [N-1:0] pattern;
    logic [N-1:0] leds;
    logic         tick;

    int checks = 0;
    int fails  = 0;

    // Model: mode in force, non-frozen cycles since entry, expiries since entry.
    logic [1:0]   m_mode;
    int           m_el;
    int           m_nexp;
    logic [N-1:0] m_seed;
    logic [N-1:0] m_leds;
    logic         m_tick;

    always #5 clk = ~clk;

    led_pattern_driver #(.NUM_LEDS(N), .HALF_PERIOD(HP)) dut (
        .clk(clk), .rst(rst), .mode(mode), .pattern(pattern),
        .freeze(freeze), .leds(leds), .tick(tick)
    );

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int k);
        logic [N-1:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[N-2:0], r[N-1]};
        return r;
    endfunction

    // One clock edge; model consumes the inputs present at that edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_mode = 2'd0; m_el = 0; m_nexp = 0; m_seed = '0; m_leds = '0; m_tick = 1'b0;
        end else if (freeze) begin
            m_tick = 1'b0;
        end else if (mode != m_mode) begin
            m_mode = mode; m_el = 0; m_nexp = 0; m_seed = pattern; m_tick = 1'b0;
            m_leds = (mode == 2'd0) ? '0 : (mode == 2'd1) ? '1 : pattern;
        end else begin
            m_el++;
            m_tick = ((m_el % HP) == 0);
            if (m_tick) m_nexp++;
            case (m_mode)
                2'd0: m_leds = '0;
                2'd1: if (m_tick) m_leds = (m_nexp % 2 == 1) ? '0 : '1;
                2'd2: m_leds = pattern;
                default: if (m_tick) m_leds = rotl(m_seed, m_nexp % N);
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; mode = 2'd0; pattern = '0;
        cycle(); cycle();
        checks++;
        if (leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset: leds=%b tick=%b, expected leds=0000 tick=0", leds, tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_blink();
        mode = 2'd1;
        cycle();
        checks++;
        if (leds !== 4'b1111) begin
            fails++;
            $display("FAIL blink_entry: leds=%b, expected 1111", leds);
        end
        for (int c = 0; c < 9; c++) begin
            cycle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                fails++;
                $display("FAIL blink cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, m_leds, m_tick);
            end
            if (c == 3) begin
                checks++;
                if (leds !== 4'b0000 || tick !== 1'b1) begin
                    fails++;
                    $display("FAIL blink_first_toggle: leds=%b tick=%b, expected 0000/1", leds, tick);
                end
            end
        end
    endtask

    task automatic test_chase();
        mode = 2'd3; pattern = 4'b0001;
        cycle();
        checks++;
        if (leds !== 4'b0001) begin
            fails++;
            $display("FAIL chase_entry: leds=%b, expected 0001", leds);
        end
        for (int c = 0; c < 18; c++) begin
            if (c == 5) pattern = 4'b1110;
            cycle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                fails++;
                $display("FAIL chase cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, m_leds, m_tick);
            end
        end
        checks++;
        if (leds !== 4'b0001) begin
            fails++;
            $display("FAIL chase_wrap: leds=%b, expected 0001", leds);
        end
    endtask

    task automatic test_solid();
        mode = 2'd2; pattern = 4'b1010;
        cycle();
        checks++;
        if (leds !== 4'b1010) begin
            fails++;
            $display("FAIL solid_entry: leds=%b, expected 1010", leds);
        end
        pattern = 4'b0110;
        cycle();
        checks++;
        if (leds !== 4'b0110) begin
            fails++;
            $display("FAIL solid_update: leds=%b, expected 0110", leds);
        end
        for (int c = 0; c < 8; c++) begin
            cycle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                fails++;
                $display("FAIL solid cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, m_leds, m_tick);
            end
        end
    endtask

    task automatic test_freeze();
        mode = 2'd1;
        cycle(); cycle(); cycle();
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (leds !== 4'b1111 || tick !== 1'b0) begin
                fails++;
                $display("FAIL freeze_hold cyc%0d: leds=%b tick=%b, expected leds=1111 tick=0", c, leds, tick);
            end
        end
        freeze = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                fails++;
                $display("FAIL freeze_resume cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, m_leds, m_tick);
            end
        end
        freeze = 1'b1; mode = 2'd0;
        cycle(); cycle();
        checks++;
        if (leds !== m_leds || leds === 4'b0000 && m_leds !== 4'b0000) begin
            fails++;
            $display("FAIL freeze_mode_hold: leds=%b, expected %b", leds, m_leds);
        end
        freeze = 1'b0;
        cycle();
        checks++;
        if (leds !== 4'b0000) begin
            fails++;
            $display("FAIL freeze_off_release: leds=%b, expected 0000", leds);
        end
    endtask

    task automatic test_rst_override();
        mode = 2'd3; pattern = 4'b0011;
        for (int c = 0; c < 6; c++) cycle();
        rst = 1'b1; freeze = 1'b1; mode = 2'd1;
        cycle();
        checks++;
        if (leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL rst_override: leds=%b tick=%b, expected leds=0000 tick=0", leds, tick);
        end
        rst = 1'b0; freeze = 1'b0; mode = 2'd0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (tick !== (c == 3) || leds !== 4'b0000) begin
                fails++;
                $display("FAIL rst_restart cyc%0d: tick=%b leds=%b, expected tick=%b leds=0000", c, tick, leds, (c == 3));
            end
        end
    endtask

    task automatic test_reentry();
        mode = 2'd1;
        cycle(); cycle(); cycle();
        mode = 2'd2; pattern = 4'b0101;
        cycle();
        mode = 2'd1;
        cycle();
        checks++;
        if (leds !== 4'b1111) begin
            fails++;
            $display("FAIL reentry_entry: leds=%b, expected 1111", leds);
        end
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (leds !== ((c == 3) ? 4'b0000 : 4'b1111) || tick !== (c == 3)) begin
                fails++;
                $display("FAIL reentry cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, (c == 3) ? 4'b0000 : 4'b1111, (c == 3));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 99) < 2);
            freeze = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 8)  mode    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 25) pattern = N'($urandom);
            cycle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                fails++;
                $display("FAIL random cyc%0d: leds=%b tick=%b, expected leds=%b tick=%b", c, leds, tick, m_leds, m_tick);
            end
        end
        rst = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blink();
        test_chase();
        test_solid();
        test_freeze();
        test_rst_override();
        test_reentry();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
